// File: rtl/lc4_commit_monitor.sv
// Commit/performance monitor: classifies each gwe-qualified cycle, counts per class, queues committed records.
// Latency: counters and FIFO tail update on the sampling edge; head record is combinational from storage.
// Backpressure: rec_valid/rec_ready drain; a full FIFO without a same-edge pop drops the record and sets overflow.
// Optional feature macro: LC4_CM_WATCH_EN (PC watchpoint that freezes sampling).
module lc4_commit_monitor #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic [1:0]       test_stall,
  input  logic [15:0]      test_cur_pc,
  input  logic [15:0]      test_cur_insn,
  input  logic             test_regfile_we,
  input  logic [2:0]       test_regfile_wsel,
  input  logic [15:0]      test_regfile_data,
  input  logic             test_nzp_we,
  input  logic [2:0]       test_nzp_new_bits,
  input  logic             test_dmem_we,
  input  logic [15:0]      test_dmem_addr,
  input  logic [15:0]      test_dmem_data,
  input  logic             clear_counts,
`ifdef LC4_CM_WATCH_EN
  input  logic [15:0]      watch_pc,
  output logic             watch_hit,
`endif
  output logic [88:0]      rec_data,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] cache_stall_count,
  output logic [CNT_W-1:0] branch_stall_count,
  output logic [CNT_W-1:0] load_stall_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic {ST_RUN, ST_FROZEN} state_t;

  state_t           state_q, state_d;
  logic             hit_q, hit_d;

  logic [88:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      occ_q, occ_d;

  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] cls_q [4];
  logic [CNT_W-1:0] drop_q;
  logic             ovf_q;

  logic             sample, push, pop, full, push_ok, drop;
  logic [88:0]      new_rec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign new_rec = {test_cur_pc, test_cur_insn, test_regfile_we, test_regfile_wsel,
                    test_regfile_data, test_nzp_we, test_nzp_new_bits, test_dmem_we,
                    test_dmem_addr, test_dmem_data};

  // A sample only exists while running; FROZEN ignores gwe entirely.
  assign sample  = gwe & (state_q == ST_RUN);
  assign push    = sample & (test_stall == 2'd0);
  assign pop     = rec_valid & rec_ready;
  assign full    = (occ_q == FULL_OCC);
  // A same-edge pop frees a slot, so a full FIFO still accepts the push.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign rec_valid = (occ_q != '0);
  assign rec_data  = rec_valid ? mem_q[rd_ptr_q] : '0;

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    occ_d = occ_q;
    if (push_ok && !pop)      occ_d = occ_q + (AW+1)'(1);
    else if (!push_ok && pop) occ_d = occ_q - (AW+1)'(1);
  end

  // FIFO pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q <= occ_d;
    end
  end

  // Record storage; contents beyond occupancy are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= new_rec;
  end

  // Saturating counters and sticky overflow; clear beats any same-edge increment.
  always_ff @(posedge clk) begin
    if (!rst || clear_counts) begin
      cycle_q <= '0;
      for (int i = 0; i < 4; i++) cls_q[i] <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (sample) begin
        cycle_q           <= sat_inc(cycle_q);
        cls_q[test_stall] <= sat_inc(cls_q[test_stall]);
      end
      if (drop) begin
        drop_q <= sat_inc(drop_q);
        ovf_q  <= 1'b1;
      end
    end
  end

  // Run/frozen state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
    end
  end

  // Next state: a committed watch-PC sample freezes; clear always returns to RUN.
  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
`ifdef LC4_CM_WATCH_EN
    if (push && (test_cur_pc == watch_pc)) begin
      state_d = ST_FROZEN;
      hit_d   = 1'b1;
    end
`endif
    if (clear_counts) begin
      state_d = ST_RUN;
      hit_d   = 1'b0;
    end
  end

`ifdef LC4_CM_WATCH_EN
  assign watch_hit = hit_q;
`endif

  assign cycle_count        = cycle_q;
  assign exec_count         = cls_q[0];
  assign cache_stall_count  = cls_q[1];
  assign branch_stall_count = cls_q[2];
  assign load_stall_count   = cls_q[3];
  assign drop_count         = drop_q;
  assign overflow           = ovf_q;

endmodule

// File: doc/lc4_commit_monitor.md
Name: lc4_commit_monitor

Overview:
- Synthesizable commit/performance monitor that sits directly downstream of lc4_processor's test_* ports, in the same position the processor testbench occupies.
- Samples one processor cycle per gwe pulse.
- Classifies the cycle as execute or cache/branch/load stall and keeps saturating counters for each class.
- Pushes every committed-instruction record into a FIFO, which is drained through a valid/ready port for a checker, UART or trace dumper.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2
CNT_W, 32, width of every counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset)
gwe  in  1  global write enable from lc4_we_gen; samples are taken only when 1
test_stall  in  2  0 = execute/commit, 1 = cache stall, 2 = branch stall, 3 = load stall
test_cur_pc  in  16  committed PC
test_cur_insn  in  16  committed instruction
test_regfile_we  in  1  register write enable
test_regfile_wsel  in  3  destination register
test_regfile_data  in  16  register write data
test_nzp_we  in  1  NZP write enable
test_nzp_new_bits  in  3  NZP value
test_dmem_we  in  1  data memory write enable
test_dmem_addr  in  16  data memory address
test_dmem_data  in  16  data memory data
clear_counts  in  1  synchronous clear of counters, overflow flag and frozen state
rec_data  out  89  head record {pc, insn, rf_we, wsel, rf_data, nzp_we, nzp, dm_we, dm_addr, dm_data}, MSB first
rec_valid  out  1  FIFO non-empty
rec_ready  in  1  consumer accepts head on this edge when rec_valid=1
cycle_count  out  CNT_W  gwe samples counted
exec_count  out  CNT_W  test_stall==0 samples
cache_stall_count  out  CNT_W  test_stall==1 samples
branch_stall_count  out  CNT_W  test_stall==2 samples
load_stall_count  out  CNT_W  test_stall==3 samples
drop_count  out  CNT_W  records lost to a full FIFO
overflow  out  1  sticky; set on the first drop

Behaviour:
- Reset (rst=0 at a clk edge): all counters 0, overflow=0, FIFO emptied (rec_valid=0, rec_data=0), state RUN. Reset applies mid-burst and discards queued records.
- States:
  - RUN: normal operation.
  - FROZEN: reachable only with the optional feature; no counting and no pushes.
- Sample: a clk edge with rst=1, gwe=1, state RUN.
  - Each sample increments cycle_count and exactly one class counter.
  - test_stall==0 additionally pushes the 89-bit record.
- No effect when gwe=0: nothing counts, pushes or changes except FIFO pops.
- Counters saturate at 2^CNT_W-1; they never wrap.
- Push latency: a record pushed at edge N is visible on rec_data/rec_valid after edge N. Push into an empty FIFO therefore shows rec_valid=1 in the next cycle.
- Pop: rec_valid & rec_ready at an edge advances the head. rec_data is the combinational head from the storage array; it reads 0 when empty.
- Full FIFO with push and no pop: the record is dropped, drop_count increments and overflow is set.
- Full FIFO with push and pop at the same edge: the push is accepted and occupancy stays DEPTH.
- Empty FIFO with push and rec_ready=1 at the same edge: no pop, since rec_valid was 0; the push is accepted.
- Pointers wrap modulo DEPTH. Occupancy is tracked with log2(DEPTH)+1 bits.
- clear_counts=1:
  - Zeroes all counters and overflow, and returns to RUN.
  - Wins over any increment at the same edge; that sample's counts are lost.
  - The push still occurs, and a pop still occurs. FIFO contents are untouched.

Optional Feature:
- Macro: LC4_CM_WATCH_EN.
- With the macro defined:
  - Adds input watch_pc[15:0] and output watch_hit (1 bit).
  - A committed sample (test_stall==0) with test_cur_pc==watch_pc is counted and pushed normally.
  - That sample then sets watch_hit=1 and moves the block to FROZEN.
  - In FROZEN, all samples are ignored and FIFO pops continue.
  - Reset or clear_counts returns the block to RUN with watch_hit=0.
  - Used to stop at a program's halt address.
- Without the macro: neither port exists and FROZEN is unreachable.

Test Plan:
- Reset, then 8 gwe samples with test_stall sequence 0,0,1,2,3,0,3,0 and rec_ready=1 → cycle=8, exec=4, cache=1, branch=1, load=2; 4 records emerge in order.
- Toggle test_stall with gwe=0 for 20 cycles → all counters unchanged, rec_valid=0.
- rec_ready=0, 18 commits with DEPTH=16 → occupancy 16, drop_count=2, overflow=1; drain gives PCs of commits 1–16 in order.
- Full FIFO, commit together with pop → occupancy stays 16, drop_count unchanged, new record at tail.
- clear_counts asserted on the same edge as a commit sample → counters 0 and overflow 0 after the edge, record still queued; assert rst=0 mid-burst → rec_valid=0 next cycle.
- LC4_CM_WATCH_EN with watch_pc=16'h8200, commits at 8200 then 8201 → exec=1, one record, watch_hit=1; clear_counts → watch_hit=0 and counting resumes.
